or_debounce_counter: RTL and testbench
======================================

// Module: or_debounce_counter
// PURPOSE
//  Sequential stage directly downstream of the 2-input OR gate. Takes the OR of A and B
//  and filters it through a debounce FSM to produce a clean level F.
//  Counts qualified rising events of F in a saturating counter.
//  Sits between raw OR-combined request/alarm lines and control logic that
//  needs glitch-free levels plus an event tally.
// PARAMETERS
//  DEB_CYCLES  4  consecutive equal samples required to change F (>=1)
//  CNT_W       8  width of event counter
// PORTS
//  clk    in   1      single clock, rising edge
//  rst    in   1      asynchronous, active-high reset
//  A      in   1      OR input 0
//  B      in   1      OR input 1
//  clr    in   1      synchronous clear of event counter
//  F      out  1      debounced OR level (registered)
//  rise   out  1      one-cycle pulse on each qualified 0->1 of F
//  count  out  CNT_W  qualified rising-event count, saturating
//  sat    out  1      high while count == all-ones
// BEHAVIOUR
//  - raw = A | B, sampled each rising clk edge (via sync stage when OR_SYNC_EN).
//  - Reset (async assert, sync-free deassert to first edge): state=S_LOW, F=0, rise=0,
//    count=0, sat=0, timer=0, sync flops=0. Reset mid-debounce aborts to S_LOW.
//  - timer width $clog2(DEB_CYCLES+1); counts consecutive samples opposing F.
//  - FSM:
//    S_LOW  (F=0): raw=1 -> timer=1; if DEB_CYCLES==1 go S_HIGH directly, else S_RISE.
//    S_RISE (F=0): raw=0 -> S_LOW, timer=0. raw=1 -> timer+1; when timer+1==DEB_CYCLES
//                  -> S_HIGH, F<=1, rise<=1, timer=0.
//    S_HIGH (F=1): raw=0 -> timer=1; DEB_CYCLES==1 -> S_LOW directly, else S_FALL.
//    S_FALL (F=1): raw=1 -> S_HIGH, timer=0. raw=0 -> timer+1; when timer+1==DEB_CYCLES
//                  -> S_LOW, F<=0, timer=0.
//  - Latency: F changes on the edge sampling the DEB_CYCLES-th consecutive opposing raw
//    value. Shorter pulses/glitches are fully rejected (no F change, no rise).
//  - rise: high exactly one cycle, same edge F goes 0->1. No pulse on 1->0.
//  - count: +1 on each rise edge; holds at 2^CNT_W-1 (no wrap). sat = (count==max), registered
//    together with count.
//  - clr and rise on same edge: count<=1 (clear then count). clr alone: count<=0, sat<=0.
//  - A and B changing simultaneously: only raw matters; A 1->0 with B 0->1 same edge = no event.
// CONFIGURATION
//  OR_SYNC_EN defined: A and B each pass a 2-flop synchronizer before OR; adds exactly 2
//    cycles latency to F/rise; sync flops reset to 0.
//  OR_SYNC_EN undefined: raw taken directly from A|B at the edge; no extra latency.
//    A, B must then be synchronous to clk.
// TESTING
//  T1 DEB_CYCLES=4, sync off: A=1 held from edge 0 -> F=1 and rise=1 at edge 3, rise=0 at
//     edge 4, count=1.
//  T2 glitch: B=1 for 3 edges then 0 (DEB=4) -> F stays 0, rise never asserts, count=0.
//  T3 fall filter: from F=1, A=B=0 for 3 edges then A=1 -> F stays 1; then 0 for 4 -> F=0,
//     no rise, count unchanged.
//  T4 CNT_W=3: 9 qualified events -> count=7, sat=1 from 7th event; clr -> count=0, sat=0.
//  T5 clr asserted on the same edge as a rise with count=5 -> count=1, sat=0.
//  T6 rst pulsed while in S_RISE (timer=2) -> all outputs 0 immediately, next rise needs full
//     DEB_CYCLES; with OR_SYNC_EN, T1 rise moves to edge 5.

Source files
------------

// File: rtl/or_debounce_counter.sv
// Debounced OR of A/B with a saturating counter of qualified rising events.
// Optional macro OR_SYNC_EN adds a 2-flop synchronizer on A and B ahead of the OR.
module or_debounce_counter #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             clr,
  output logic             F,
  output logic             rise,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam int TW = $clog2(DEB_CYCLES + 1);
  localparam logic [TW-1:0]    TIMER_LAST = TW'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam bit               SINGLE     = (DEB_CYCLES == 1);

  typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             f_q, f_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             raw;

`ifdef OR_SYNC_EN
  logic [1:0] a_sync_q, b_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[0], A};
      b_sync_q <= {b_sync_q[0], B};
    end
  end

  assign raw = a_sync_q[1] | b_sync_q[1];
`else
  assign raw = A | B;
`endif

  // NOTE: every output is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    f_d     = f_q;
    rise_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (raw) begin
          if (SINGLE) begin
            state_d = S_HIGH;
            f_d     = 1'b1;
            rise_d  = 1'b1;
            timer_d = '0;
          end else begin
            state_d = S_RISE;
            timer_d = TW'(1);
          end
        end
      end
      S_RISE: begin
        if (!raw) begin
          state_d = S_LOW;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d = S_HIGH;
          f_d     = 1'b1;
          rise_d  = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_HIGH: begin
        if (!raw) begin
          if (SINGLE) begin
            state_d = S_LOW;
            f_d     = 1'b0;
            timer_d = '0;
          end else begin
            state_d = S_FALL;
            timer_d = TW'(1);
          end
        end
      end
      S_FALL: begin
        if (raw) begin
          state_d = S_HIGH;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d = S_LOW;
          f_d     = 1'b0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        timer_d = '0;
        f_d     = 1'b0;
      end
    endcase
  end

  // Clear wins over the old value but not over a simultaneous rise.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = rise_d ? CNT_W'(1) : '0;
    end else if (rise_d && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
    sat_d = (count_d == CNT_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOW;
      timer_q <= '0;
      f_q     <= 1'b0;
      rise_q  <= 1'b0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      f_q     <= f_d;
      rise_q  <= rise_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign F     = f_q;
  assign rise  = rise_q;
  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_or_debounce_counter.sv
// Directed bench for or_debounce_counter: a run-length reference model feeds a
// latency queue of expected {F, rise}; the counter expectation is advanced at pop time.
module tb_or_debounce_counter;

  localparam int DEB = 4;
  localparam int CW  = 3;
  localparam logic [CW-1:0] CMAX = '1;
`ifdef OR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst, a, b, clr;
  logic f, rise, sat;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]    exp_q[$];
  logic          m_f, m_last;
  int            m_run;
  logic [CW-1:0] m_cnt;

  always #5 clk = ~clk;

  or_debounce_counter #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (a),
    .B    (b),
    .clr  (clr),
    .F    (f),
    .rise (rise),
    .count(count),
    .sat  (sat)
  );

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_f    = 1'b0;
    m_last = 1'b0;
    m_run  = 0;
    m_cnt  = '0;
    exp_q.delete();
    repeat (LAT) exp_q.push_back(2'b00);
  endtask

  // Called just after a falling edge; checks outputs while reset is held.
  task automatic do_reset();
    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;
    clr = 1'b0;
    #2;
    model_reset();
    check("rst_f", f, 1'b0);
    check("rst_rise", rise, 1'b0);
    check("rst_count", count, '0);
    check("rst_sat", sat, 1'b0);
    #1 rst = 1'b0;
  endtask

  task automatic cycle(input logic ai, input logic bi, input logic ci);
    logic       raw, r;
    logic [1:0] e;
    a   = ai;
    b   = bi;
    clr = ci;
    raw = ai | bi;
    if (raw == m_last) m_run++;
    else begin
      m_last = raw;
      m_run  = 1;
    end
    r = 1'b0;
    if ((raw != m_f) && (m_run >= DEB)) begin
      m_f = raw;
      r   = raw;
    end
    exp_q.push_back({m_f, r});
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    if (ci) m_cnt = e[0] ? CW'(1) : '0;
    else if (e[0] && (m_cnt != CMAX)) m_cnt = m_cnt + CW'(1);
    check("f", f, e[1]);
    check("rise", rise, e[0]);
    check("count", count, m_cnt);
    check("sat", sat, m_cnt == CMAX);
  endtask

  task automatic qualified_event();
    repeat (DEB + LAT) cycle(1'b1, 1'b0, 1'b0);
    repeat (DEB + LAT) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    a   = 1'b0;
    b   = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    do_reset();

    // T1: A held high; F and rise on the DEB-th sample
    repeat (DEB - 1 + LAT) cycle(1'b1, 1'b0, 1'b0);
    check("t1_f_before", f, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("t1_f", f, 1'b1);
    check("t1_rise", rise, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    check("t1_rise_off", rise, 1'b0);
    check("t1_count", count, CW'(1));

    // T2: 3-sample glitch on B is rejected
    @(negedge clk);
    do_reset();
    repeat (DEB - 1) cycle(1'b0, 1'b1, 1'b0);
    repeat (DEB + LAT) cycle(1'b0, 1'b0, 1'b0);
    check("t2_f", f, 1'b0);
    check("t2_count", count, '0);

    // T3: A/B swapping keeps raw high; short low gap rejected, full low run accepted
    for (int i = 0; i < DEB + LAT; i++) cycle(i % 2 == 0, i % 2 == 1, 1'b0);
    check("t3_f_high", f, 1'b1);
    repeat (DEB - 1) cycle(1'b0, 1'b0, 1'b0);
    repeat (1 + LAT) cycle(1'b1, 1'b0, 1'b0);
    check("t3_f_hold", f, 1'b1);
    repeat (DEB + LAT) cycle(1'b0, 1'b0, 1'b0);
    check("t3_f_low", f, 1'b0);
    check("t3_count", count, CW'(1));

    // T4: saturation with CNT_W=3, then clear
    @(negedge clk);
    do_reset();
    repeat (7) qualified_event();
    check("t4_count7", count, CMAX);
    check("t4_sat7", sat, 1'b1);
    repeat (2) qualified_event();
    check("t4_count9", count, CMAX);
    check("t4_sat9", sat, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check("t4_clr_count", count, '0);
    check("t4_clr_sat", sat, 1'b0);

    // T5: clear coinciding with a rise at count 5
    repeat (5) qualified_event();
    check("t5_count5", count, CW'(5));
    repeat (DEB - 1 + LAT) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    check("t5_rise", rise, 1'b1);
    check("t5_count", count, CW'(1));
    check("t5_sat", sat, 1'b0);

    // T6: reset in the middle of a rising debounce
    repeat (DEB + LAT) cycle(1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    do_reset();
    repeat (DEB - 1 + LAT) cycle(1'b1, 1'b0, 1'b0);
    check("t6_f_before", f, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("t6_f", f, 1'b1);
    check("t6_rise", rise, 1'b1);
    check("t6_count", count, CW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
